// File: rtl/vga_fetch.sv
// vga_fetch: framebuffer fetcher for the VGA pixel pipeline.
// Walks the framebuffer one 72-bit DRAM word at a time through the memctl
// VGA port, buffers returned words in a small FIFO and unpacks each word into
// nine RGB332 pixels, byte 0 first. At most one read is ever in flight.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   frame_start   pulse: flush FIFO and restart fetch at FB_BASE
//   VgaRq         read request to memctl (registered)
//   VgaAddr       word address of the request, stable while VgaRq is high
//   MemReadyVga   memctl accepts the request when high together with VgaRq
//   VgaData       read data, valid RD_LAT cycles after acceptance
//   pix_rd        consumer pops the current pixel
//   pix_data      current pixel, 0 when the FIFO is empty
//   pix_valid     FIFO non-empty
//   underflow     sticky: pix_rd seen while pix_valid low
module vga_fetch #(
  parameter logic [31:0] FB_BASE     = 32'h0000_0000,
  parameter int unsigned FRAME_WORDS = 34134,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic        VgaRq,
  output logic [31:0] VgaAddr,
  input  logic        MemReadyVga,
  input  logic [71:0] VgaData,
  input  logic        pix_rd,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic        underflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} state_t;

  state_t        state, stateNext;
  logic [71:0]   fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count, countNext;
  logic [3:0]    idx;
  logic [19:0]   wordsLeft;
  logic [2:0]    latCnt;
  logic          discard;

  logic          accept, dataCycle, push, advance, pop;
  logic [71:0]   head;

  assign accept    = VgaRq & MemReadyVga;
  assign dataCycle = (state == WAIT) && (latCnt == 3'd0);
  // A flush in the same cycle overrides any push or pop.
  assign push      = dataCycle && !discard && !frame_start;
  assign advance   = pix_rd && pix_valid && !frame_start;
  assign pop       = advance && (idx == 4'd8);
  assign countNext = count + CW'(push) - CW'(pop);

  assign head      = fifoMem[rdPtr];
  assign pix_valid = (count != '0);

  always_comb begin
    pix_data = '0;
    if (pix_valid) pix_data = head[{idx, 3'b000} +: 8];
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = IDLE;
      REQ:  if (accept) stateNext = WAIT;
      WAIT: if (dataCycle) begin
              if (discard)                        stateNext = REQ;
              else if (wordsLeft == 20'd1)        stateNext = DONE;
              else if (countNext < CW'(FIFO_DEPTH)) stateNext = REQ;
              else                                stateNext = HOLD;
            end
      HOLD: if (count < CW'(FIFO_DEPTH)) stateNext = REQ;
      DONE: stateNext = DONE;
      default: stateNext = IDLE;
    endcase
    // A read still in flight must be drained before re-requesting; if its
    // data arrives this very cycle it is simply dropped.
    if (frame_start) begin
      if (state == WAIT && !dataCycle) stateNext = WAIT;
      else                             stateNext = REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      VgaRq     <= 1'b0;
      VgaAddr   <= FB_BASE;
      wordsLeft <= '0;
      latCnt    <= '0;
      discard   <= 1'b0;
      underflow <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      idx       <= '0;
    end else begin
      state <= stateNext;
      VgaRq <= (stateNext == REQ);

      if (state == REQ && accept)            latCnt <= 3'(RD_LAT - 1);
      else if (state == WAIT && latCnt != 3'd0) latCnt <= latCnt - 3'd1;

      if (frame_start) begin
        VgaAddr   <= FB_BASE;
        wordsLeft <= 20'(FRAME_WORDS);
        discard   <= (state == WAIT) && !dataCycle;
        underflow <= 1'b0;
        wrPtr     <= '0;
        rdPtr     <= '0;
        count     <= '0;
        idx       <= '0;
      end else begin
        if (dataCycle) begin
          discard <= 1'b0;
          if (!discard) begin
            VgaAddr   <= VgaAddr + 32'd1;
            wordsLeft <= wordsLeft - 20'd1;
          end
        end
        if (pix_rd && !pix_valid) underflow <= 1'b1;
        if (push) wrPtr <= wrPtr + 1'b1;
        if (advance) begin
          if (idx == 4'd8) begin
            idx   <= '0;
            rdPtr <= rdPtr + 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        count <= countNext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= VgaData;
  end

endmodule
